// File: rtl/vga_regs_pkg.sv
// Shared definitions for the VGA pointer register bank: register map, writer FSM states, indicator colours.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vga_regs_pkg;

    // Register map of the pointer bank (address -> field)
    localparam int ADDR_SEG_R  = 1;
    localparam int ADDR_MIN_R  = 2;
    localparam int ADDR_HOR_R  = 3;
    localparam int ADDR_YEAR_R = 4;
    localparam int ADDR_MON_R  = 5;
    localparam int ADDR_DAY_R  = 6;
    localparam int ADDR_SEG_C  = 7;
    localparam int ADDR_MIN_C  = 8;
    localparam int ADDR_HOR_C  = 9;
    localparam int ADDR_RING_C = 10;
    localparam int ADDR_ACT_C  = 11;
    localparam int ADDR_CURSOR = 12;

    // Writer FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_WRITE,
        ST_GAP,
        ST_DONE
    } wr_state_t;

    // Indicator colours (RGB332), shared with the renderer
    localparam logic [7:0] COLOR_IND_OFF  = 8'h00;
    localparam logic [7:0] COLOR_IND_RING = 8'hE0;
    localparam logic [7:0] COLOR_IND_ACT  = 8'h1C;

endpackage

// File: rtl/vga_vsync_edge.sv
// VSync edge detector: one history flop, combinational fall/rise flags.
// Latency: flags valid in the same cycle VSync changes (relative to the previous sample).
// Backpressure: none; history resets to 1 so a VSync held low at reset release reads as a fall.
module vga_vsync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic fall,
    output logic rise
);

    logic vs_q;

    // Remember last cycle's VSync level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vsync;
        end
    end

    assign fall = vs_q & ~vsync;
    assign rise = ~vs_q & vsync;

endmodule

// File: rtl/vga_reg_writer.sv
// Snapshots clock/date/timer/indicator/cursor once per frame and writes them to the pointer bank during VSync low.
// Latency: first Write 2 cycles after the edge seeing VSync fall; one write per (1+WR_GAP) cycles; Done 1 cycle after last write.
// Backpressure: none on the bus; a VSync rise mid-burst gates Write at once and abandons the burst with an Aborted pulse.
module vga_reg_writer
    import vga_regs_pkg::*;
#(
    parameter int FIRST_ADDR = ADDR_SEG_R,
    parameter int LAST_ADDR  = ADDR_CURSOR,
    parameter int WR_GAP     = 0,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VSync,
    input  logic              Enable,
    input  logic [7:0]        segReloj,
    input  logic [7:0]        minReloj,
    input  logic [7:0]        horReloj,
    input  logic [7:0]        yearReloj,
    input  logic [7:0]        monReloj,
    input  logic [7:0]        dayReloj,
    input  logic [7:0]        segCrono,
    input  logic [7:0]        minCrono,
    input  logic [7:0]        horCrono,
    input  logic              ringCrono,
    input  logic              actCrono,
    input  logic [7:0]        Cursor,
    output logic [ADDR_W-1:0] MemAddrOut,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              Write,
    output logic              Busy,
    output logic              Done,
    output logic              Aborted
);

    localparam int SLOTS = 2 ** ADDR_W;

    wr_state_t         state, state_nxt;
    logic              fall, rise, in_burst;
    logic [ADDR_W-1:0] addr_cnt, addr_cnt_nxt, addr_nxt;
    logic [2:0]        gap_cnt, gap_cnt_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              write_q, write_nxt, busy_nxt, done_nxt, aborted_nxt, snap_en;
    logic [7:0]        snap [SLOTS];

    // Live input value that belongs at register address a
    function automatic logic [7:0] snap_src(input int a);
        case (a)
            ADDR_SEG_R:  return segReloj;
            ADDR_MIN_R:  return minReloj;
            ADDR_HOR_R:  return horReloj;
            ADDR_YEAR_R: return yearReloj;
            ADDR_MON_R:  return monReloj;
            ADDR_DAY_R:  return dayReloj;
            ADDR_SEG_C:  return segCrono;
            ADDR_MIN_C:  return minCrono;
            ADDR_HOR_C:  return horCrono;
            ADDR_RING_C: return {7'b0, ringCrono};
            ADDR_ACT_C:  return {7'b0, actCrono};
            ADDR_CURSOR: return Cursor;
            default:     return 8'h00;
        endcase
    endfunction

    vga_vsync_edge u_edge (
        .clk   (CLK),
        .rst_n (RESET),
        .vsync (VSync),
        .fall  (fall),
        .rise  (rise)
    );

    // States during which a VSync rise cancels the burst
    always_comb begin
        in_burst = (state == ST_SNAP) || (state == ST_WRITE) || (state == ST_GAP);
    end

    // The registered strobe is cut combinationally so no write leaks past the end of blanking
    assign Write = write_q & ~(in_burst & rise);

    // Next-state and next-output decode
    always_comb begin
        state_nxt    = state;
        addr_cnt_nxt = addr_cnt;
        gap_cnt_nxt  = gap_cnt;
        addr_nxt     = MemAddrOut;
        data_nxt     = MemDataOut;
        write_nxt    = 1'b0;
        busy_nxt     = Busy;
        done_nxt     = 1'b0;
        aborted_nxt  = 1'b0;
        snap_en      = 1'b0;
        if (in_burst && rise) begin
            state_nxt   = ST_IDLE;
            busy_nxt    = 1'b0;
            aborted_nxt = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fall && Enable) begin
                        state_nxt = ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    snap_en      = 1'b1;
                    addr_cnt_nxt = ADDR_W'(FIRST_ADDR);
                    busy_nxt     = 1'b1;
                    state_nxt    = ST_WRITE;
                end
                ST_WRITE: begin
                    write_nxt = 1'b1;
                    addr_nxt  = addr_cnt;
                    data_nxt  = DATA_W'(snap[addr_cnt]);
                    if (addr_cnt == ADDR_W'(LAST_ADDR)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        addr_cnt_nxt = addr_cnt + 1'b1;
                        if (WR_GAP > 0) begin
                            gap_cnt_nxt = 3'(WR_GAP - 1);
                            state_nxt   = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 3'd0) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        gap_cnt_nxt = gap_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters and registered bus/status outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_cnt   <= '0;
            gap_cnt    <= '0;
            MemAddrOut <= '0;
            MemDataOut <= '0;
            write_q    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Aborted    <= 1'b0;
        end else begin
            addr_cnt   <= addr_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            MemAddrOut <= addr_nxt;
            MemDataOut <= data_nxt;
            write_q    <= write_nxt;
            Busy       <= busy_nxt;
            Done       <= done_nxt;
            Aborted    <= aborted_nxt;
        end
    end

    // Snapshot bank: captured once per burst so the whole frame is coherent
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int a = 0; a < SLOTS; a++) begin
                snap[a] <= '0;
            end
        end else if (snap_en) begin
            for (int a = 0; a < SLOTS; a++) begin
                snap[a] <= snap_src(a);
            end
        end
    end

endmodule
